// File: rtl/sy_l2_cache_victim_sel_pkg.sv
// Shared constants and types for the L2 victim-selection stage.
package sy_l2_cache_victim_sel_pkg;

  localparam int L2_CACHE_WAY_NUM = 8;
  localparam int L2_CACHE_WAY_WTH = 3;
  localparam int L2_CACHE_SET_WTH = 7;

  typedef struct packed {
    logic [L2_CACHE_SET_WTH-1:0] set;
    logic [L2_CACHE_WAY_WTH-1:0] way;
    logic                        inv;
  } l2_victim_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WAIT   = 2'd2,
    OUT    = 2'd3
  } l2_vsel_state_e;

endpackage

// File: rtl/sy_l2_cache_victim_sel_if.sv
// Request, LRU lookup/update, hit and victim signals of the victim selector.
interface sy_l2_cache_victim_sel_if
  import sy_l2_cache_victim_sel_pkg::*;
#(
  parameter int WAY_NUM = L2_CACHE_WAY_NUM,
  parameter int WAY_WTH = L2_CACHE_WAY_WTH,
  parameter int SET_WTH = L2_CACHE_SET_WTH
) ();

  logic               req_vld_i;
  logic               req_rdy_o;
  logic [SET_WTH-1:0] req_set_i;
  logic [WAY_NUM-1:0] way_vld_i;
  logic [WAY_NUM-1:0] way_busy_i;
  logic [SET_WTH-1:0] lru_set_o;
  logic [WAY_WTH-1:0] lru_way_i;
  logic               hit_upd_i;
  logic [SET_WTH-1:0] hit_set_i;
  logic [WAY_WTH-1:0] hit_way_i;
  logic               victim_vld_o;
  logic               victim_rdy_i;
  logic [SET_WTH-1:0] victim_set_o;
  logic [WAY_WTH-1:0] victim_way_o;
  logic               victim_inv_o;
  logic               upd_lru_o;
  logic [SET_WTH-1:0] upd_set_o;
  logic [WAY_WTH-1:0] upd_way_o;

  modport slave (
    input  req_vld_i, req_set_i, way_vld_i, way_busy_i, lru_way_i,
    input  hit_upd_i, hit_set_i, hit_way_i, victim_rdy_i,
    output req_rdy_o, lru_set_o, victim_vld_o, victim_set_o, victim_way_o,
    output victim_inv_o, upd_lru_o, upd_set_o, upd_way_o
  );

  modport master (
    output req_vld_i, req_set_i, way_vld_i, way_busy_i, lru_way_i,
    output hit_upd_i, hit_set_i, hit_way_i, victim_rdy_i,
    input  req_rdy_o, lru_set_o, victim_vld_o, victim_set_o, victim_way_o,
    input  victim_inv_o, upd_lru_o, upd_set_o, upd_way_o
  );

endinterface

// File: rtl/sy_l2_cache_victim_sel_way_pick.sv
// Combinational victim pick: free invalid way, then LRU way, then lowest free valid way.
module sy_l2_cache_victim_sel_way_pick
  import sy_l2_cache_victim_sel_pkg::*;
#(
  parameter int WAY_NUM = L2_CACHE_WAY_NUM,
  parameter int WAY_WTH = L2_CACHE_WAY_WTH
) (
  input  logic [WAY_NUM-1:0] way_vld_i,
  input  logic [WAY_NUM-1:0] way_busy_i,
  input  logic [WAY_WTH-1:0] lru_way_i,
  output logic               found_o,
  output logic [WAY_WTH-1:0] way_o,
  output logic               inv_o
);

  logic [WAY_NUM-1:0] free_way;
  logic [WAY_NUM-1:0] inv_way;
  logic               inv_hit;
  logic [WAY_WTH-1:0] inv_idx;
  logic               free_hit;
  logic [WAY_WTH-1:0] free_idx;
  logic               lru_ok;

  assign free_way = ~way_busy_i;
  assign inv_way  = ~way_vld_i & ~way_busy_i;

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    inv_hit  = 1'b0;
    inv_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    lru_ok   = 1'b0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      inv_hit  = inv_hit | inv_way[i];
      inv_idx  = inv_way[i] ? WAY_WTH'(i) : inv_idx;
      free_hit = free_hit | free_way[i];
      free_idx = free_way[i] ? WAY_WTH'(i) : free_idx;
      lru_ok   = lru_ok | ((lru_way_i == WAY_WTH'(i)) & free_way[i]);
    end
  end

  // Priority resolution of the three candidate classes.
  always_comb begin
    found_o = 1'b0;
    way_o   = '0;
    inv_o   = 1'b0;
    if (inv_hit) begin
      found_o = 1'b1;
      way_o   = inv_idx;
      inv_o   = 1'b1;
    end else if (lru_ok) begin
      found_o = 1'b1;
      way_o   = lru_way_i;
      inv_o   = 1'b0;
    end else begin
      found_o = free_hit;
      way_o   = free_idx;
      inv_o   = 1'b0;
    end
  end

endmodule

// File: rtl/sy_l2_cache_victim_sel.sv
// L2 victim selection: LRU lookup, busy-aware way pick and LRU update arbitration.
module sy_l2_cache_victim_sel
  import sy_l2_cache_victim_sel_pkg::*;
#(
  parameter int WAY_NUM = L2_CACHE_WAY_NUM,
  parameter int WAY_WTH = L2_CACHE_WAY_WTH,
  parameter int SET_WTH = L2_CACHE_SET_WTH
) (
  input logic                    clk_i,
  input logic                    rst_i,
  sy_l2_cache_victim_sel_if.slave bus
);

  l2_vsel_state_e     state_q, state_d;
  logic [SET_WTH-1:0] set_q, set_d;
  logic [WAY_NUM-1:0] vld_q, vld_d;
  logic               stale_q, stale_d;
  logic [WAY_WTH-1:0] lru_q, lru_d;
  logic               vic_vld_q, vic_vld_d;
  logic [SET_WTH-1:0] vic_set_q, vic_set_d;
  logic [WAY_WTH-1:0] vic_way_q, vic_way_d;
  logic               vic_inv_q, vic_inv_d;
  logic               rdy_q, rdy_d;
  logic               pend_vld_q, pend_vld_d;
  logic [SET_WTH-1:0] pend_set_q, pend_set_d;
  logic [WAY_WTH-1:0] pend_way_q, pend_way_d;

  logic               accept;
  logic               alloc_req;
  logic [WAY_WTH-1:0] pick_lru;
  logic               pick_found;
  logic [WAY_WTH-1:0] pick_way;
  logic               pick_inv;
  logic               upd_lru;
  logic [SET_WTH-1:0] upd_set;
  logic [WAY_WTH-1:0] upd_way;

  // In WAIT the LRU port may already show another set, so use the captured way.
  assign pick_lru = (state_q == WAIT) ? lru_q : bus.lru_way_i;

  sy_l2_cache_victim_sel_way_pick #(
    .WAY_NUM (WAY_NUM),
    .WAY_WTH (WAY_WTH)
  ) u_way_pick (
    .way_vld_i  (vld_q),
    .way_busy_i (bus.way_busy_i),
    .lru_way_i  (pick_lru),
    .found_o    (pick_found),
    .way_o      (pick_way),
    .inv_o      (pick_inv)
  );

  assign accept    = (state_q == IDLE) && bus.req_vld_i && rdy_q;
  assign alloc_req = (state_q == OUT) && vic_vld_q && bus.victim_rdy_i;

  // Next-state and datapath for the victim FSM.
  always_comb begin
    state_d   = state_q;
    set_d     = set_q;
    vld_d     = vld_q;
    stale_d   = stale_q;
    lru_d     = lru_q;
    vic_vld_d = vic_vld_q;
    vic_set_d = vic_set_q;
    vic_way_d = vic_way_q;
    vic_inv_d = vic_inv_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          set_d   = bus.req_set_i;
          vld_d   = bus.way_vld_i;
          stale_d = bus.hit_upd_i && (bus.hit_set_i == bus.req_set_i);
          state_d = LOOKUP;
        end else begin
          stale_d = 1'b0;
        end
      end
      LOOKUP: begin
        lru_d   = bus.lru_way_i;
        stale_d = 1'b0;
        if (stale_q) begin
          state_d = LOOKUP;
        end else if (pick_found) begin
          vic_vld_d = 1'b1;
          vic_set_d = set_q;
          vic_way_d = pick_way;
          vic_inv_d = pick_inv;
          state_d   = OUT;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (pick_found) begin
          vic_vld_d = 1'b1;
          vic_set_d = set_q;
          vic_way_d = pick_way;
          vic_inv_d = pick_inv;
          state_d   = OUT;
        end else begin
          state_d = WAIT;
        end
      end
      OUT: begin
        if (bus.victim_rdy_i) begin
          vic_vld_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d   = IDLE;
        vic_vld_d = 1'b0;
      end
    endcase
  end

  // Hit updates win the port; a displaced allocation update waits in pend.
  always_comb begin
    upd_lru    = 1'b0;
    upd_set    = '0;
    upd_way    = '0;
    pend_vld_d = pend_vld_q;
    pend_set_d = pend_set_q;
    pend_way_d = pend_way_q;
    if (bus.hit_upd_i) begin
      upd_lru = 1'b1;
      upd_set = bus.hit_set_i;
      upd_way = bus.hit_way_i;
      if (alloc_req) begin
        pend_vld_d = 1'b1;
        pend_set_d = vic_set_q;
        pend_way_d = vic_way_q;
      end else begin
        pend_vld_d = pend_vld_q;
      end
    end else if (pend_vld_q) begin
      upd_lru    = 1'b1;
      upd_set    = pend_set_q;
      upd_way    = pend_way_q;
      pend_vld_d = 1'b0;
    end else if (alloc_req) begin
      upd_lru = 1'b1;
      upd_set = vic_set_q;
      upd_way = vic_way_q;
    end else begin
      upd_lru = 1'b0;
    end
  end

  // Registered ready keeps victim_rdy_i off any combinational path to req_rdy_o.
  assign rdy_d = (state_d == IDLE) && !pend_vld_d;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      set_q      <= '0;
      vld_q      <= '0;
      stale_q    <= 1'b0;
      lru_q      <= '0;
      vic_vld_q  <= 1'b0;
      vic_set_q  <= '0;
      vic_way_q  <= '0;
      vic_inv_q  <= 1'b0;
      rdy_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_set_q <= '0;
      pend_way_q <= '0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      vld_q      <= vld_d;
      stale_q    <= stale_d;
      lru_q      <= lru_d;
      vic_vld_q  <= vic_vld_d;
      vic_set_q  <= vic_set_d;
      vic_way_q  <= vic_way_d;
      vic_inv_q  <= vic_inv_d;
      rdy_q      <= rdy_d;
      pend_vld_q <= pend_vld_d;
      pend_set_q <= pend_set_d;
      pend_way_q <= pend_way_d;
    end
  end

  assign bus.req_rdy_o    = rdy_q;
  assign bus.lru_set_o    = (state_q == IDLE) ? bus.req_set_i : set_q;
  assign bus.victim_vld_o = vic_vld_q;
  assign bus.victim_set_o = vic_set_q;
  assign bus.victim_way_o = vic_way_q;
  assign bus.victim_inv_o = vic_inv_q;
  assign bus.upd_lru_o    = upd_lru;
  assign bus.upd_set_o    = upd_set;
  assign bus.upd_way_o    = upd_way;

endmodule

// File: tb/tb_sy_l2_cache_victim_sel.sv
// Bench for the L2 victim selector: vector table, random traffic and corner sequences.
module tb_sy_l2_cache_victim_sel;
  import sy_l2_cache_victim_sel_pkg::*;

  typedef struct {
    logic [6:0] set;
    logic [7:0] vld;
    logic [7:0] busy;
    logic [2:0] lru;
    logic       hit;
    logic [6:0] hset;
    logic [2:0] hway;
    logic [2:0] exp_way;
    logic       exp_inv;
    int         exp_lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs[10];

  sy_l2_cache_victim_sel_if bus ();

  sy_l2_cache_victim_sel dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference pick: classify non-busy ways, then apply the preference order.
  function automatic logic [4:0] model_pick(input logic [7:0] v, input logic [7:0] b,
                                            input logic [2:0] lru);
    int inv_q[$];
    int val_q[$];
    for (int i = 0; i < 8; i++) begin
      if (!b[i]) begin
        if (!v[i]) inv_q.push_back(i);
        else val_q.push_back(i);
      end
    end
    if (inv_q.size() > 0) return {1'b1, 1'b1, 3'(inv_q[0])};
    if (!b[lru]) return {1'b1, 1'b0, lru};
    if (val_q.size() > 0) return {1'b1, 1'b0, 3'(val_q[0])};
    return 5'd0;
  endfunction

  task automatic idle_inputs();
    bus.req_vld_i    = 1'b0;
    bus.req_set_i    = 7'd0;
    bus.way_vld_i    = 8'd0;
    bus.way_busy_i   = 8'd0;
    bus.lru_way_i    = 3'd0;
    bus.hit_upd_i    = 1'b0;
    bus.hit_set_i    = 7'd0;
    bus.hit_way_i    = 3'd0;
    bus.victim_rdy_i = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.req_rdy_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, 32'(bus.req_rdy_o), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int         n;
    l2_victim_t got;
    wait_ready(tag);
    bus.req_vld_i  = 1'b1;
    bus.req_set_i  = v.set;
    bus.way_vld_i  = v.vld;
    bus.way_busy_i = v.busy;
    bus.lru_way_i  = v.lru;
    bus.hit_upd_i  = v.hit;
    bus.hit_set_i  = v.hset;
    bus.hit_way_i  = v.hway;
    #1;
    chk({tag, "_lruset"}, 32'(bus.lru_set_o), 32'(v.set));
    step();
    bus.req_vld_i = 1'b0;
    bus.hit_upd_i = 1'b0;
    n = 1;
    while (bus.victim_vld_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    got = '{bus.victim_set_o, bus.victim_way_o, bus.victim_inv_o};
    chk({tag, "_lat"}, 32'(n), 32'(v.exp_lat));
    chk({tag, "_set"}, 32'(got.set), 32'(v.set));
    chk({tag, "_way"}, 32'(got.way), 32'(v.exp_way));
    chk({tag, "_inv"}, 32'(got.inv), 32'(v.exp_inv));
    bus.victim_rdy_i = 1'b1;
    #1;
    chk({tag, "_upd"}, 32'({bus.upd_lru_o, bus.upd_set_o, bus.upd_way_o}),
        32'({1'b1, v.set, v.exp_way}));
    step();
    bus.victim_rdy_i = 1'b0;
    bus.way_busy_i   = 8'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, 32'(bus.req_rdy_o), 32'd0);
    chk({tag, "_vic"}, 32'({bus.victim_vld_o, bus.victim_set_o, bus.victim_way_o,
                             bus.victim_inv_o}), 32'd0);
    chk({tag, "_upd"}, 32'({bus.upd_lru_o, bus.upd_set_o, bus.upd_way_o}), 32'd0);
    chk({tag, "_lruset"}, 32'(bus.lru_set_o), 32'd0);
  endtask

  initial begin
    vec_t       rv;
    logic [4:0] m;
    total = 0;
    bad   = 0;

    vecs[0] = '{7'h12, 8'hDF, 8'h00, 3'd2, 1'b0, 7'h00, 3'd0, 3'd5, 1'b1, 2};
    vecs[1] = '{7'h03, 8'hFF, 8'h00, 3'd6, 1'b0, 7'h00, 3'd0, 3'd6, 1'b0, 2};
    vecs[2] = '{7'h05, 8'hFF, 8'h41, 3'd6, 1'b0, 7'h00, 3'd0, 3'd1, 1'b0, 2};
    vecs[3] = '{7'h7F, 8'h00, 8'h01, 3'd0, 1'b0, 7'h00, 3'd0, 3'd1, 1'b1, 2};
    vecs[4] = '{7'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 7'h00, 3'd0, 3'd0, 1'b0, 2};
    vecs[5] = '{7'h21, 8'h7F, 8'h80, 3'd3, 1'b0, 7'h00, 3'd0, 3'd3, 1'b0, 2};
    vecs[6] = '{7'h2A, 8'hFE, 8'hFE, 3'd5, 1'b0, 7'h00, 3'd0, 3'd0, 1'b1, 2};
    vecs[7] = '{7'h33, 8'hFF, 8'h7F, 3'd2, 1'b0, 7'h00, 3'd0, 3'd7, 1'b0, 2};
    vecs[8] = '{7'h12, 8'hFF, 8'h00, 3'd1, 1'b1, 7'h12, 3'd4, 3'd1, 1'b0, 3};
    vecs[9] = '{7'h12, 8'hFF, 8'h00, 3'd1, 1'b1, 7'h13, 3'd4, 3'd1, 1'b0, 2};

    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk("reset_rel_rdy", 32'(bus.req_rdy_o), 32'd1);

    // Hit forwarding while idle.
    bus.hit_upd_i = 1'b1;
    bus.hit_set_i = 7'h03;
    bus.hit_way_i = 3'd4;
    #1;
    chk("hit_fwd", 32'({bus.upd_lru_o, bus.upd_set_o, bus.upd_way_o}), 32'({1'b1, 7'h03, 3'd4}));
    step();
    bus.hit_upd_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      rv.set  = 7'($urandom_range(0, 127));
      rv.vld  = 8'($urandom_range(0, 255)) | 8'($urandom_range(0, 255));
      rv.busy = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      rv.lru  = 3'($urandom_range(0, 7));
      m = model_pick(rv.vld, rv.busy, rv.lru);
      if (!m[4]) begin
        rv.busy = rv.busy & ~(8'd1 << rv.lru);
        m = model_pick(rv.vld, rv.busy, rv.lru);
      end
      rv.hit     = 1'($urandom_range(0, 1));
      rv.hset    = ($urandom_range(0, 1) == 1) ? rv.set : 7'($urandom_range(0, 127));
      rv.hway    = 3'($urandom_range(0, 7));
      rv.exp_way = m[2:0];
      rv.exp_inv = m[3];
      rv.exp_lat = (rv.hit && rv.hset == rv.set) ? 3 : 2;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // All ways busy: stall in WAIT until way 3 frees up.
    wait_ready("wait");
    bus.req_vld_i  = 1'b1;
    bus.req_set_i  = 7'h44;
    bus.way_vld_i  = 8'hFF;
    bus.way_busy_i = 8'hFF;
    bus.lru_way_i  = 3'd0;
    step();
    bus.req_vld_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wait_stall%0d", i), 32'(bus.victim_vld_o), 32'd0);
      step();
    end
    bus.lru_way_i  = 3'd5;
    bus.way_busy_i = 8'hF7;
    step();
    chk("wait_vld", 32'(bus.victim_vld_o), 32'd1);
    chk("wait_way", 32'({bus.victim_way_o, bus.victim_inv_o}), 32'({3'd3, 1'b0}));
    bus.victim_rdy_i = 1'b1;
    step();
    bus.victim_rdy_i = 1'b0;
    bus.way_busy_i   = 8'd0;

    // Allocation update collides with a hit update and is deferred one cycle.
    wait_ready("coll");
    bus.req_vld_i = 1'b1;
    bus.req_set_i = 7'h04;
    bus.way_vld_i = 8'hFB;
    bus.lru_way_i = 3'd0;
    step();
    bus.req_vld_i = 1'b0;
    step();
    chk("coll_vic", 32'({bus.victim_vld_o, bus.victim_set_o, bus.victim_way_o}),
        32'({1'b1, 7'h04, 3'd2}));
    bus.victim_rdy_i = 1'b1;
    bus.hit_upd_i    = 1'b1;
    bus.hit_set_i    = 7'h09;
    bus.hit_way_i    = 3'd7;
    #1;
    chk("coll_hit", 32'({bus.upd_lru_o, bus.upd_set_o, bus.upd_way_o}), 32'({1'b1, 7'h09, 3'd7}));
    step();
    bus.victim_rdy_i = 1'b0;
    bus.hit_upd_i    = 1'b0;
    #1;
    chk("coll_pend", 32'({bus.upd_lru_o, bus.upd_set_o, bus.upd_way_o}), 32'({1'b1, 7'h04, 3'd2}));
    chk("coll_rdy_low", 32'(bus.req_rdy_o), 32'd0);
    step();
    chk("coll_done", 32'({bus.upd_lru_o, bus.req_rdy_o}), 32'({1'b0, 1'b1}));

    // Reset while stalled in WAIT aborts the request.
    wait_ready("rstw");
    bus.req_vld_i  = 1'b1;
    bus.req_set_i  = 7'h55;
    bus.way_vld_i  = 8'hFF;
    bus.way_busy_i = 8'hFF;
    step();
    bus.req_vld_i = 1'b0;
    bus.req_set_i = 7'h00;
    step();
    step();
    chk("rstw_lruset", 32'(bus.lru_set_o), 32'h55);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstw");
    step();
    bus.way_busy_i = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    chk("rstw_novic", 32'(bus.victim_vld_o), 32'd0);
    chk("rstw_rdy", 32'(bus.req_rdy_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
